operand_load_sequencer: RTL

- Controller that sequences a two-operand datapath (ALU or multiplier) from one shared input bus and one "data ready" button.
- Captures operand A, then operand B, on successive rising edges of inputdata_ready, then issues a one-cycle start to the datapath.
- Waits for the datapath's done, then holds result_valid for a fixed display window.
- Sits between the board input logic and the arithmetic datapath / display driver.

---
 rtl/operand_load_sequencer_pkg.sv | 16 +
 rtl/operand_load_sequencer_edge_det.sv | 22 ++
 rtl/operand_load_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/operand_load_sequencer_pkg.sv
// Shared types for the operand load sequencer: state encoding (also shown on LEDs).
package seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        WAIT_A = 3'd0,
        LOAD_A = 3'd1,
        WAIT_B = 3'd2,
        LOAD_B = 3'd3,
        START  = 3'd4,
        EXEC   = 3'd5,
        SHOW   = 3'd6
    } state_t;

endpackage

// File: rtl/operand_load_sequencer_edge_det.sv
// Rising-edge detector for the already-synchronized "data ready" button level.
module rising_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic prev_r;

    // History resets high so a button held through reset release gives no edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= in;
        end
    end

    assign rise = in & ~prev_r;

endmodule

// File: rtl/operand_load_sequencer.sv
// Sequences operand A/B capture from a shared bus, starts the datapath and holds the result.
// Optional EXEC watchdog with sticky err flag is built when SEQ_TIMEOUT_EN is defined.
module operand_load_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inputdata_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              dp_done,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              load_a,
    output logic              load_b,
    output logic              start,
    output logic              busy,
    output logic              result_valid,
    output logic              err,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    if (HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("HOLD_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    state_t              state_r, state_s;
    logic [DATA_W-1:0]   op_a_r, op_b_r;
    logic [HOLD_W-1:0]   hold_r, hold_s;
    logic                cap_a_s, cap_b_s, rise_s;
    logic                load_a_r, load_b_r, start_r, busy_r, result_valid_r;

`ifdef SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]     to_r, to_s;
    logic                to_exp_s, err_r;
`endif

    rising_edge_det u_edge (
        .clk   (clk),
        .reset (reset),
        .in    (inputdata_ready),
        .rise  (rise_s)
    );

    // Next-state, capture strobes and counter updates.
    always_comb begin
        state_s = state_r;
        hold_s  = hold_r;
        cap_a_s = 1'b0;
        cap_b_s = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        to_s     = '0;
        to_exp_s = 1'b0;
`endif
        case (state_r)
            WAIT_A: begin
                if (rise_s) begin
                    cap_a_s = 1'b1;
                    state_s = LOAD_A;
                end else begin
                    state_s = WAIT_A;
                end
            end
            LOAD_A: state_s = WAIT_B;
            WAIT_B: begin
                if (rise_s) begin
                    cap_b_s = 1'b1;
                    state_s = LOAD_B;
                end else begin
                    state_s = WAIT_B;
                end
            end
            LOAD_B: state_s = START;
            START:  state_s = EXEC;
            EXEC: begin
                // dp_done beats a simultaneous watchdog expiry.
                if (dp_done) begin
                    state_s = SHOW;
                    hold_s  = '0;
`ifdef SEQ_TIMEOUT_EN
                end else if (to_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_s  = WAIT_A;
                    to_exp_s = 1'b1;
                end else begin
                    to_s    = to_r + 1'b1;
                    state_s = EXEC;
                end
`else
                end else begin
                    state_s = EXEC;
                end
`endif
            end
            SHOW: begin
                // A new button edge restarts immediately, ahead of window expiry.
                if (rise_s) begin
                    cap_a_s = 1'b1;
                    state_s = LOAD_A;
                end else if (hold_r == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_s = WAIT_A;
                end else begin
                    hold_s  = hold_r + 1'b1;
                    state_s = SHOW;
                end
            end
            default: state_s = WAIT_A;
        endcase
    end

    // State, operands and Moore outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= WAIT_A;
            hold_r         <= '0;
            op_a_r         <= '0;
            op_b_r         <= '0;
            load_a_r       <= 1'b0;
            load_b_r       <= 1'b0;
            start_r        <= 1'b0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            hold_r         <= hold_s;
            op_a_r         <= cap_a_s ? data_in : op_a_r;
            op_b_r         <= cap_b_s ? data_in : op_b_r;
            load_a_r       <= (state_s == LOAD_A);
            load_b_r       <= (state_s == LOAD_B);
            start_r        <= (state_s == START);
            busy_r         <= (state_s == START) || (state_s == EXEC);
            result_valid_r <= (state_s == SHOW);
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Watchdog count and sticky error; err only clears on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_r  <= '0;
            err_r <= 1'b0;
        end else begin
            to_r  <= to_s;
            err_r <= err_r | to_exp_s;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign op_a         = op_a_r;
    assign op_b         = op_b_r;
    assign load_a       = load_a_r;
    assign load_b       = load_b_r;
    assign start        = start_r;
    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign state_dbg    = state_r;

endmodule
